// File: rtl/seg7_multi_disp.sv
// Registered NDIGIT seven-segment controller for the factorization game, with a
// staged question reveal and a blinking result glyph. Optional macro: SEG7_LZB_EN.
module seg7_multi_disp #(
    parameter int NDIGIT     = 4,
    parameter int REVEAL_DIV = 12_500_000,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            STATE,
    input  logic [4*NDIGIT-1:0]   QUE,
    input  logic [4*NDIGIT-1:0]   DIN,
    output logic [7*NDIGIT-1:0]   nHEX,
    output logic                  BUSY
);
    localparam int RW  = $clog2(NDIGIT + 1);
    localparam int RW1 = RW + 1;
    localparam int RTW = (REVEAL_DIV > 1) ? $clog2(REVEAL_DIV) : 1;
    localparam int BTW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_INPUT    = 4'b0100;
    localparam logic [3:0] ST_DRAW     = 4'b0110;
    localparam logic [3:0] ST_WRONG    = 4'b0111;
    localparam logic [3:0] ST_GOOD     = 4'b1000;
    localparam logic [3:0] ST_OUCH     = 4'b1001;
    localparam logic [3:0] ST_WIN      = 4'b1010;
    localparam logic [3:0] ST_LOSE     = 4'b1011;

    localparam logic [6:0] G_Y     = 7'b0010001;
    localparam logic [6:0] G_D     = 7'b0100001;
    localparam logic [6:0] G_L     = 7'b1000111;
    localparam logic [6:0] G_H     = 7'b0001001;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_T     = 7'b0000111;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    function automatic logic [6:0] dec_glyph(input logic [3:0] v);
        case (v)
            4'd0:    dec_glyph = 7'b1000000;
            4'd1:    dec_glyph = 7'b1111001;
            4'd2:    dec_glyph = 7'b0100100;
            4'd3:    dec_glyph = 7'b0110000;
            4'd4:    dec_glyph = 7'b0011001;
            4'd5:    dec_glyph = 7'b0010010;
            4'd6:    dec_glyph = 7'b0000010;
            4'd7:    dec_glyph = 7'b1011000;
            4'd8:    dec_glyph = 7'b0000000;
            4'd9:    dec_glyph = 7'b0010000;
            default: dec_glyph = G_BLANK;
        endcase
    endfunction

    // Key codes map onto the digits printed on the game keypad.
    function automatic logic [6:0] key_glyph(input logic [3:0] k);
        case (k)
            4'd0:    key_glyph = G_DASH;
            4'd1:    key_glyph = dec_glyph(4'd2);
            4'd2:    key_glyph = dec_glyph(4'd3);
            4'd3:    key_glyph = dec_glyph(4'd5);
            4'd4:    key_glyph = dec_glyph(4'd7);
            4'd5:    key_glyph = dec_glyph(4'd1);
            4'd6:    key_glyph = dec_glyph(4'd3);
            4'd7:    key_glyph = dec_glyph(4'd7);
            4'd8:    key_glyph = dec_glyph(4'd9);
            4'd9:    key_glyph = dec_glyph(4'd3);
            default: key_glyph = G_BLANK;
        endcase
    endfunction

    function automatic logic is_result(input logic [3:0] st);
        is_result = (st == ST_GOOD) || (st == ST_WRONG) || (st == ST_OUCH) ||
                    (st == ST_DRAW) || (st == ST_WIN)   || (st == ST_LOSE);
    endfunction

    function automatic logic [6:0] digit_seg(
        input logic [3:0] st,
        input logic       is_lsd,
        input logic [3:0] q,
        input logic [3:0] d,
        input logic       vis,
        input logic       lzb,
        input logic       ph
    );
        digit_seg = G_BLANK;
        case (st)
            ST_READY:    digit_seg = G_Y;
            ST_QUESTION: if (vis && !lzb) digit_seg = dec_glyph(q);
            ST_INPUT:    digit_seg = key_glyph(d);
            ST_GOOD:     if (is_lsd && ph) digit_seg = G_D;
            ST_WRONG:    if (is_lsd && ph) digit_seg = G_L;
            ST_OUCH:     if (is_lsd && ph) digit_seg = G_H;
            ST_DRAW:     if (is_lsd && ph) digit_seg = G_E;
            ST_WIN:      if (is_lsd && ph) digit_seg = G_T;
            ST_LOSE:     if (is_lsd && ph) digit_seg = G_E;
            default:     digit_seg = G_BLANK;
        endcase
    endfunction

    logic [3:0]          prev_state_reg;
    logic [4*NDIGIT-1:0] que_reg;
    logic [4*NDIGIT-1:0] din_reg;
    logic [RW-1:0]       rev_reg;
    logic [RTW-1:0]      rev_timer_reg;
    logic                phase_reg;
    logic [BTW-1:0]      blink_timer_reg;
    logic [7*NDIGIT-1:0] nhex_reg;
    logic                busy_reg;

    logic                entry;
    logic [NDIGIT-1:0]   visible;
    logic [NDIGIT-1:0]   lz_blank;
    logic [7*NDIGIT-1:0] nhex_next;
    logic                busy_next;

    // prev_state_reg doubles as the input stage, so decode and counters stay aligned.
    assign entry     = (STATE != prev_state_reg);
    assign busy_next = (prev_state_reg == ST_QUESTION) && (rev_reg < RW'(NDIGIT));

    generate
        for (genvar gi = 0; gi < NDIGIT; gi++) begin : g_digit
            assign visible[gi] = ({1'b0, rev_reg} >= RW1'(NDIGIT - gi));
`ifdef SEG7_LZB_EN
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else if (gi == NDIGIT - 1) begin : g_msd
                assign lz_blank[gi] = (que_reg[4*gi +: 4] == 4'd0);
            end else begin : g_mid
                assign lz_blank[gi] = (que_reg[4*gi +: 4] == 4'd0) &&
                                      (que_reg[4*NDIGIT-1 : 4*(gi+1)] == '0);
            end
`else
            assign lz_blank[gi] = 1'b0;
`endif
            assign nhex_next[7*gi +: 7] = digit_seg(prev_state_reg, (gi == 0),
                                                    que_reg[4*gi +: 4], din_reg[4*gi +: 4],
                                                    visible[gi], lz_blank[gi], phase_reg);
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_state_reg  <= 4'b0000;
            que_reg         <= '0;
            din_reg         <= '0;
            rev_reg         <= '0;
            rev_timer_reg   <= '0;
            phase_reg       <= 1'b1;
            blink_timer_reg <= '0;
            nhex_reg        <= '1;
            busy_reg        <= 1'b0;
        end else begin
            prev_state_reg <= STATE;
            que_reg        <= QUE;
            din_reg        <= DIN;
            nhex_reg       <= nhex_next;
            busy_reg       <= busy_next;

            if (STATE == ST_QUESTION) begin
                if (entry) begin
                    rev_reg       <= RW'(1);
                    rev_timer_reg <= '0;
                end else if (rev_reg < RW'(NDIGIT)) begin
                    if (rev_timer_reg == RTW'(REVEAL_DIV - 1)) begin
                        rev_timer_reg <= '0;
                        rev_reg       <= rev_reg + RW'(1);
                    end else begin
                        rev_timer_reg <= rev_timer_reg + RTW'(1);
                    end
                end
            end else begin
                rev_reg       <= '0;
                rev_timer_reg <= '0;
            end

            if (is_result(STATE)) begin
                if (entry) begin
                    phase_reg       <= 1'b1;
                    blink_timer_reg <= '0;
                end else if (blink_timer_reg == BTW'(BLINK_DIV - 1)) begin
                    blink_timer_reg <= '0;
                    phase_reg       <= ~phase_reg;
                end else begin
                    blink_timer_reg <= blink_timer_reg + BTW'(1);
                end
            end else begin
                phase_reg       <= 1'b1;
                blink_timer_reg <= '0;
            end
        end
    end

    assign nHEX = nhex_reg;
    assign BUSY = busy_reg;
endmodule

// File: tb/tb_seg7_multi_disp.sv
// Directed bench for seg7_multi_disp with NDIGIT=2, REVEAL_DIV=4, BLINK_DIV=3.
module tb_seg7_multi_disp;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1011000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] GY = 7'b0010001;
    localparam logic [6:0] GD = 7'b0100001;
    localparam logic [6:0] GT = 7'b0000111;
    localparam logic [6:0] GS = 7'b0111111;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic [7:0]  que;
    logic [7:0]  din;
    logic [13:0] nhex;
    logic        busy;

    int checks = 0;
    int passed = 0;

    seg7_multi_disp #(.NDIGIT(2), .REVEAL_DIV(4), .BLINK_DIV(3)) dut (
        .CLK(clk), .RST(rst), .STATE(state), .QUE(que), .DIN(din), .nHEX(nhex), .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_init();
        rst = 1'b1; state = 4'h0; que = 8'h00; din = 8'h00;
        #2;
        checks++;
        if (nhex !== 14'h3FFF) $display("FAIL init_nhex: got %h want 3fff", nhex); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL init_busy: got %b want 0", busy); else passed++;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_ready();
        state = 4'b0010;
        tick(2);
        checks++;
        if (nhex !== {GY, GY}) $display("FAIL ready_y: got %h want %h", nhex, {GY, GY}); else passed++;
        state = 4'hF;
        tick(1);
        checks++;
        if (nhex !== {GY, GY}) $display("FAIL ready_latency: got %h want %h", nhex, {GY, GY}); else passed++;
        tick(1);
        checks++;
        if (nhex !== 14'h3FFF) $display("FAIL unknown_blank: got %h want 3fff", nhex); else passed++;
    endtask

    task automatic test_reveal();
        state = 4'b0011; que = 8'h47;
        tick(2);
        checks++;
        if (nhex !== {D4, BL}) $display("FAIL reveal_msd: got %h want %h", nhex, {D4, BL}); else passed++;
        checks++;
        if (busy !== 1'b1) $display("FAIL reveal_busy: got %b want 1", busy); else passed++;
        tick(3);
        checks++;
        if (nhex !== {D4, BL}) $display("FAIL reveal_hold: got %h want %h", nhex, {D4, BL}); else passed++;
        checks++;
        if (busy !== 1'b1) $display("FAIL reveal_hold_busy: got %b want 1", busy); else passed++;
        tick(1);
        checks++;
        if (nhex !== {D4, D7}) $display("FAIL reveal_lsd: got %h want %h", nhex, {D4, D7}); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reveal_done_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_que_update();
        state = 4'hF;
        tick(2);
        state = 4'b0011; que = 8'h47;
        tick(2);
        que = 8'h97;
        tick(2);
        checks++;
        if (nhex !== {D9, BL}) $display("FAIL que_update: got %h want %h", nhex, {D9, BL}); else passed++;
        checks++;
        if (busy !== 1'b1) $display("FAIL que_update_busy: got %b want 1", busy); else passed++;
        tick(2);
        checks++;
        if (nhex !== {D9, D7}) $display("FAIL que_no_restart: got %h want %h", nhex, {D9, D7}); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL que_done_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_abort();
        state = 4'hF;
        tick(2);
        state = 4'b0011; que = 8'h47;
        tick(2);
        state = 4'hF;
        tick(1);
        state = 4'b0011;
        tick(2);
        checks++;
        if (nhex !== {D4, BL}) $display("FAIL abort_restart: got %h want %h", nhex, {D4, BL}); else passed++;
        checks++;
        if (busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", busy); else passed++;
        tick(3);
        checks++;
        if (nhex !== {D4, BL}) $display("FAIL abort_hold: got %h want %h", nhex, {D4, BL}); else passed++;
        tick(1);
        checks++;
        if (nhex !== {D4, D7}) $display("FAIL abort_lsd: got %h want %h", nhex, {D4, D7}); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL abort_done_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_input();
        state = 4'b0100; din = 8'h30;
        tick(2);
        checks++;
        if (nhex !== {D5, GS}) $display("FAIL input_30: got %h want %h", nhex, {D5, GS}); else passed++;
        din = 8'hA1;
        tick(2);
        checks++;
        if (nhex !== {BL, D2}) $display("FAIL input_a1: got %h want %h", nhex, {BL, D2}); else passed++;
    endtask

    task automatic test_blink();
        logic [9:0] on_mask;
        logic [13:0] exp;
        on_mask = 10'b0111000111;
        state = 4'b1000;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            exp = on_mask[i] ? {BL, GD} : {BL, BL};
            checks++;
            if (nhex !== exp) $display("FAIL blink_cycle%0d: got %h want %h", i, nhex, exp); else passed++;
        end
        state = 4'b1010;
        tick(1);
        checks++;
        if (nhex !== {BL, BL}) $display("FAIL blink_switch_latency: got %h want %h", nhex, {BL, BL}); else passed++;
        tick(1);
        checks++;
        if (nhex !== {BL, GT}) $display("FAIL blink_restart_t: got %h want %h", nhex, {BL, GT}); else passed++;
    endtask

    task automatic test_reset_mid();
        state = 4'b0011; que = 8'h47;
        tick(2);
        checks++;
        if (nhex !== {D4, BL}) $display("FAIL pre_reset: got %h want %h", nhex, {D4, BL}); else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (nhex !== 14'h3FFF) $display("FAIL reset_async_nhex: got %h want 3fff", nhex); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_async_busy: got %b want 0", busy); else passed++;
        tick(1);
        rst = 1'b0;
        tick(2);
        checks++;
        if (nhex !== {D4, BL}) $display("FAIL reset_reentry: got %h want %h", nhex, {D4, BL}); else passed++;
        checks++;
        if (busy !== 1'b1) $display("FAIL reset_reentry_busy: got %b want 1", busy); else passed++;
    endtask

    task automatic test_lzb();
        logic [13:0] exp;
`ifdef SEG7_LZB_EN
        exp = {BL, D5};
`else
        exp = {D0, D5};
`endif
        state = 4'hF;
        tick(2);
        state = 4'b0011; que = 8'h05;
        tick(6);
        checks++;
        if (nhex !== exp) $display("FAIL leading_zero: got %h want %h", nhex, exp); else passed++;
    endtask

    initial begin
        test_reset_init();
        test_ready();
        test_reveal();
        test_que_update();
        test_abort();
        test_input();
        test_blink();
        test_reset_mid();
        test_lzb();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
